// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: client request/response lanes plus the RAM-side port.
interface mem_port_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_write;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_error;
    logic                     mem_en;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin N-channel arbiter in front of a single-ported fixed-latency RAM.
// Optional MEM_ARB_ALIGN_CHECK_EN rejects misaligned addresses with an error response.
module mem_port_arbiter #(
    parameter int NUM_CH      = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    mem_port_arbiter_if.master bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [PTR_W-1:0]    ptr_r, ptr_nxt_s, grant_idx_s, cand_s;
    logic [NUM_CH-1:0]   grant_oh_s, owner_r;
    logic                grant_found_s, accept_s, capture_s, misalign_s;
    logic                sel_write_s, write_r;
    logic [ADDR_W-1:0]   sel_addr_s, mem_addr_r;
    logic [DATA_W-1:0]   sel_wdata_s, mem_wdata_r, rsp_rdata_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                mem_en_r, mem_we_r, rsp_error_r;
    logic [NUM_CH-1:0]   rsp_valid_r;

    // Round-robin search: scanning downward lets the smallest offset from the pointer win.
    always_comb begin
        grant_idx_s = '0;
        cand_s      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand_s      = PTR_W'((int'(ptr_r) + i) % NUM_CH);
            grant_idx_s = bus.req_valid[cand_s] ? cand_s : grant_idx_s;
        end
    end

    assign grant_found_s = |bus.req_valid;
    assign grant_oh_s    = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_idx_s;
    assign ptr_nxt_s     = (grant_idx_s == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx_s + PTR_W'(1);
    assign sel_write_s   = bus.req_write[grant_idx_s];
    assign sel_addr_s    = bus.req_addr[grant_idx_s*ADDR_W +: ADDR_W];
    assign sel_wdata_s   = bus.req_wdata[grant_idx_s*DATA_W +: DATA_W];

`ifdef MEM_ARB_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W/8 - 1);
    assign misalign_s = |(sel_addr_s & ALIGN_MASK);
`else
    assign misalign_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; req_ready is masked by RESET so every output reads 0 while held in reset.
    always_comb begin
        state_nxt_s   = state_r;
        accept_s      = 1'b0;
        capture_s     = 1'b0;
        bus.req_ready = '0;
        case (state_r)
            IDLE: begin
                if (grant_found_s && !RESET) begin
                    accept_s                   = 1'b1;
                    bus.req_ready[grant_idx_s] = 1'b1;
                    state_nxt_s                = misalign_s ? RESP : ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (cnt_r == CNT_W'(1)) begin
                    capture_s   = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Transaction capture, one-cycle memory strobe and one-cycle response registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr_r       <= '0;
            owner_r     <= '0;
            write_r     <= 1'b0;
            cnt_r       <= '0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
            rsp_error_r <= 1'b0;
        end else begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
            rsp_error_r <= 1'b0;
            if (accept_s) begin
                ptr_r   <= ptr_nxt_s;
                owner_r <= grant_oh_s;
                write_r <= sel_write_s;
                if (misalign_s) begin
                    rsp_valid_r <= grant_oh_s;
                    rsp_error_r <= 1'b1;
                end else begin
                    mem_en_r    <= 1'b1;
                    mem_we_r    <= sel_write_s;
                    mem_addr_r  <= sel_addr_s;
                    mem_wdata_r <= sel_wdata_s;
                end
            end else if (state_r == ISSUE) begin
                cnt_r <= CNT_W'(MEM_LATENCY);
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - CNT_W'(1);
                if (capture_s) begin
                    rsp_valid_r <= owner_r;
                    rsp_rdata_r <= write_r ? '0 : bus.mem_rdata;
                end else begin
                    rsp_valid_r <= '0;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_error = rsp_error_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 1;
    localparam int L3 = 3;
    localparam logic [31:0] JUNK = 32'hA5A5_5A5A;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    mem_port_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_port_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L))
        dut (.CLK(clk), .RESET(rst), .bus(bus.master));
    mem_port_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L3))
        dut3 (.CLK(clk), .RESET(rst), .bus(bus3.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Background RAM content: word 0x40 (byte 0x100) holds 0xDEADBEEF.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        logic [7:0] w;
        w = a[9:2];
        if (w == 8'h40) return 32'hDEAD_BEEF;
        return {8'h5A, w, ~w, 8'hC3};
    endfunction

    function automatic bit tb_misaligned(input logic [31:0] a);
        return ALIGN_EN && (a[1:0] != 2'b00);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // RAM for the latency-1 DUT: one-cycle read data, junk on every other cycle.
    bit   [31:0] ram [256];
    bit          ram_wr [256];
    logic [31:0] rd1_r = JUNK;
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            ram[bus.mem_addr[9:2]]    <= bus.mem_wdata;
            ram_wr[bus.mem_addr[9:2]] <= 1'b1;
        end
        if (bus.mem_en && !bus.mem_we)
            rd1_r <= ram_wr[bus.mem_addr[9:2]] ? ram[bus.mem_addr[9:2]] : init_val(bus.mem_addr);
        else
            rd1_r <= JUNK;
    end
    assign bus.mem_rdata = rd1_r;

    // Three-stage read pipe for the latency-3 DUT.
    logic [31:0] p3_0 = JUNK, p3_1 = JUNK, p3_2 = JUNK;
    always @(posedge clk) begin
        p3_0 <= bus3.mem_en ? init_val(bus3.mem_addr) : JUNK;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign bus3.mem_rdata = p3_2;

    // Transaction model: an accepted request completes a fixed number of cycles after acceptance.
    bit   [31:0] shadow [256];
    bit          sh_wr [256];
    bit          m_busy = 1'b0, m_mis, m_we;
    int          m_t0, m_rd, m_own, g, d;
    int          m_ptr = 0;
    int          mcyc = 0;
    logic [31:0] m_addr, m_wd, m_rdata;
    logic [N-1:0] e_ready, e_rv;
    logic        e_en, e_we, e_err;
    logic [31:0] e_addr, e_wd, e_rdata;

    always @(negedge clk) begin
        e_ready = '0; e_rv = '0; e_en = 1'b0; e_we = 1'b0; e_err = 1'b0;
        e_addr = '0; e_wd = '0; e_rdata = '0;
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) begin
                e_ready[g] = 1'b1;
                m_own  = g;
                m_we   = bus.req_write[g];
                m_addr = bus.req_addr[g*AW +: AW];
                m_wd   = bus.req_wdata[g*DW +: DW];
                m_mis  = tb_misaligned(m_addr);
                m_t0   = mcyc;
                m_busy = 1'b1;
                m_ptr  = (g + 1) % N;
                m_rd   = m_mis ? 1 : 2 + L;
                m_rdata = (m_we || m_mis) ? 32'h0 :
                          (sh_wr[m_addr[9:2]] ? shadow[m_addr[9:2]] : init_val(m_addr));
                if (m_we && !m_mis) begin
                    shadow[m_addr[9:2]] = m_wd;
                    sh_wr[m_addr[9:2]]  = 1'b1;
                end
            end
        end else begin
            d = mcyc - m_t0;
            if (d == 1 && !m_mis) begin
                e_en = 1'b1; e_we = m_we; e_addr = m_addr; e_wd = m_wd;
            end
            if (d == m_rd) begin
                e_rv[m_own] = 1'b1;
                e_rdata     = m_rdata;
                e_err       = m_mis;
                m_busy      = 1'b0;
            end
        end
        check("model_req_ready", bus.req_ready, e_ready);
        check("model_mem_en",    bus.mem_en,    e_en);
        check("model_mem_we",    bus.mem_we,    e_we);
        check("model_mem_addr",  bus.mem_addr,  e_addr);
        check("model_mem_wdata", bus.mem_wdata, e_wd);
        check("model_rsp_valid", bus.rsp_valid, e_rv);
        check("model_rsp_rdata", bus.rsp_rdata, e_rdata);
        check("model_rsp_error", bus.rsp_error, e_err);
        mcyc++;
    end

    task automatic set_ch(input int k, input logic w, input logic [31:0] a, input logic [31:0] wd);
        bus.req_write[k]        = w;
        bus.req_addr[k*AW +: AW] = a;
        bus.req_wdata[k*DW +: DW] = wd;
    endtask

    task automatic wait_grant(input int k, output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.req_ready[k]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout ch%0d: got no req_ready in 40 cycles, expected a grant", k);
        end
    endtask

    // Issue one request on channel k; returns just after the edge that ends the accept cycle.
    task automatic single(input int k, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          output int t);
        @(posedge clk); #1;
        set_ch(k, w, a, wd);
        bus.req_valid[k] = 1'b1;
        wait_grant(k, t);
        @(posedge clk); #1;
        bus.req_valid[k] = 1'b0;
    endtask

    int t, n;
    int gch [4];
    int gt  [4];

    initial begin
        bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus3.req_valid = '0; bus3.req_write = '0; bus3.req_addr = '0; bus3.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_mem_en", bus.mem_en, 1'b0);
        check("reset_rsp_valid", bus.rsp_valid, 3'b000);
        @(posedge clk); #1 rst = 1'b0;

        // Single read on ch1
        single(1, 1'b0, 32'h100, 32'h0, t);
        @(negedge clk);
        check("rd_mem_en", bus.mem_en, 1'b1);
        check("rd_mem_we", bus.mem_we, 1'b0);
        check("rd_mem_addr", bus.mem_addr, 32'h100);
        @(negedge clk);
        check("rd_no_early_rsp", bus.rsp_valid, 3'b000);
        @(negedge clk);
        check("rd_rsp_valid", bus.rsp_valid, 3'b010);
        check("rd_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);

        // Single write on ch2
        single(2, 1'b1, 32'h200, 32'h1234_5678, t);
        @(negedge clk);
        check("wr_mem_en", bus.mem_en, 1'b1);
        check("wr_mem_we", bus.mem_we, 1'b1);
        check("wr_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        repeat (2) @(negedge clk);
        check("wr_rsp_valid", bus.rsp_valid, 3'b100);
        check("wr_rsp_rdata", bus.rsp_rdata, 32'h0);

        // Read back the write on ch0
        single(0, 1'b0, 32'h200, 32'h0, t);
        repeat (3) @(negedge clk);
        check("rb_rsp_valid", bus.rsp_valid, 3'b001);
        check("rb_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);

        // Round robin with all channels valid from reset
        @(posedge clk); #1 rst = 1'b1;
        set_ch(0, 1'b0, 32'h40, 32'h0);
        set_ch(1, 1'b0, 32'h44, 32'h0);
        set_ch(2, 1'b1, 32'h48, 32'hCAFE_0002);
        bus.req_valid = 3'b111;
        @(negedge clk);
        check("reset_ready_masked", bus.req_ready, 3'b000);
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin gch[i] = -1; gt[i] = 0; end
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (|bus.req_ready) begin
                for (int k = 0; k < N; k++) if (bus.req_ready[k]) gch[n] = k;
                gt[n] = cyc;
                n++;
            end
        end
        @(posedge clk); #1 bus.req_valid = '0;
        check("rr_count", n, 4);
        check("rr_g0", gch[0], 0);
        check("rr_g1", gch[1], 1);
        check("rr_g2", gch[2], 2);
        check("rr_g3", gch[3], 0);
        check("rr_gap01", gt[1] - gt[0], 4);
        check("rr_gap23", gt[3] - gt[2], 4);
        repeat (6) @(negedge clk);

        // Reset during WAIT
        single(2, 1'b0, 32'h100, 32'h0, t);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("async_mem_en", bus.mem_en, 1'b0);
        check("async_rsp_valid", bus.rsp_valid, 3'b000);
        check("async_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("async_mem_addr", bus.mem_addr, 32'h0);
        set_ch(0, 1'b0, 32'h0, 32'h0);
        set_ch(1, 1'b0, 32'h4, 32'h0);
        set_ch(2, 1'b0, 32'h8, 32'h0);
        bus.req_valid = 3'b111;
        @(negedge clk);
        check("reset_no_rsp", bus.rsp_valid, 3'b000);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_grant", bus.req_ready, 3'b001);
        @(posedge clk); #1 bus.req_valid = '0;
        repeat (5) @(negedge clk);

        // Misaligned read on ch0
        single(0, 1'b0, 32'h102, 32'h0, t);
        @(negedge clk);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        check("mis_no_mem_en", bus.mem_en, 1'b0);
        check("mis_rsp_valid", bus.rsp_valid, 3'b001);
        check("mis_rsp_error", bus.rsp_error, 1'b1);
        check("mis_rsp_rdata", bus.rsp_rdata, 32'h0);
`else
        check("mis_mem_en", bus.mem_en, 1'b1);
        check("mis_mem_addr", bus.mem_addr, 32'h102);
        repeat (2) @(negedge clk);
        check("mis_rsp_valid", bus.rsp_valid, 3'b001);
        check("mis_rsp_error", bus.rsp_error, 1'b0);
`endif
        repeat (4) @(negedge clk);

        // Latency-3 instance: ch0 read while ch1 keeps requesting
        @(posedge clk); #1;
        bus3.req_addr[0*AW +: AW] = 32'h300;
        bus3.req_addr[1*AW +: AW] = 32'h304;
        bus3.req_valid = 3'b011;
        @(negedge clk);
        check("l3_accept", bus3.req_ready, 3'b001);
        @(posedge clk); #1 bus3.req_valid = 3'b010;
        for (int dd = 1; dd <= 5; dd++) begin
            if (dd > 1) @(negedge clk);
            else @(negedge clk);
            check($sformatf("l3_ready_T%0d", dd), bus3.req_ready, 3'b000);
            if (dd == 4) check("l3_no_early_rsp", bus3.rsp_valid, 3'b000);
            if (dd == 5) begin
                check("l3_rsp_valid", bus3.rsp_valid, 3'b001);
                check("l3_rsp_rdata", bus3.rsp_rdata, {8'h5A, 8'hC0, 8'h3F, 8'hC3});
            end
        end
        @(negedge clk);
        check("l3_next_grant", bus3.req_ready, 3'b010);
        @(posedge clk); #1 bus3.req_valid = '0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
